// File: rtl/note_judge.sv
// Per-lane hit/miss grading against note arrivals, with running score and combo.
// Each lane keeps its own timing window; the grades feed a shared score/combo accumulator.
module note_judge #(
  parameter int LANES       = 4,
  parameter int WINDOW      = 15,
  parameter int SCORE_W     = 16,
  parameter int COMBO_BONUS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         mode,
  input  logic               game_start,
  input  logic [LANES-1:0]   press,
  input  logic [LANES-1:0]   note_arrive,
  output logic [LANES-1:0]   hit,
  output logic [LANES-1:0]   miss,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_WINDOW = 1'b1
  } lane_state_t;

  localparam int SUM_W = SCORE_W + 9;
  // cnt is 0 on the first cycle after arrival, so the last accepted cycle sees WINDOW-2.
  localparam logic [7:0] LAST_CNT = (WINDOW >= 2) ? 8'(WINDOW - 2) : 8'd0;
  localparam logic [7:0] BONUS_AT = 8'(COMBO_BONUS);

  lane_state_t      state_q [LANES];
  lane_state_t      state_d [LANES];
  logic [7:0]       cnt_q   [LANES];
  logic [7:0]       cnt_d   [LANES];
  logic [LANES-1:0] hit_p0;
  logic [LANES-1:0] miss_p0;
  logic [LANES-1:0] hit_p1;
  logic [LANES-1:0] miss_p1;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_d;
  logic [7:0]       combo_p1;
  logic [7:0]       combo_d;
  logic [7:0]       nh;
  logic             active;

  function automatic logic [7:0] count_hits(input logic [LANES-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + 8'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s,
                                                   input logic [7:0] n,
                                                   input logic dbl);
    logic [SUM_W-1:0] incr;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] top;
    incr = dbl ? (SUM_W'(n) << 1) : SUM_W'(n);
    sum  = SUM_W'(s) + incr;
    top  = SUM_W'({SCORE_W{1'b1}});
    if (sum > top) begin
      return {SCORE_W{1'b1}};
    end
    return sum[SCORE_W-1:0];
  endfunction

  function automatic logic [7:0] sat_combo(input logic [7:0] c,
                                           input logic [7:0] n,
                                           input logic any_miss);
    logic [8:0] sum;
    sum = {1'b0, c} + {1'b0, n};
    if (any_miss) begin
      return 8'd0;
    end
    if (sum > 9'd255) begin
      return 8'd255;
    end
    return sum[7:0];
  endfunction

  assign active = (mode == 3'd4);

  // Stage p0: per-lane window FSM and grade decision.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      hit_p0[i]  = 1'b0;
      miss_p0[i] = 1'b0;
      if (!active) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = 8'd0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (note_arrive[i] && press[i]) begin
              hit_p0[i] = 1'b1;
            end else if (note_arrive[i]) begin
              if (WINDOW == 1) begin
                miss_p0[i] = 1'b1;
              end else begin
                state_d[i] = ST_WINDOW;
                cnt_d[i]   = 8'd0;
              end
            end else if (press[i]) begin
              miss_p0[i] = 1'b1;
            end
          end
          ST_WINDOW: begin
            if (press[i]) begin
              hit_p0[i]  = 1'b1;
              state_d[i] = ST_IDLE;
              cnt_d[i]   = 8'd0;
            end else if (note_arrive[i]) begin
              miss_p0[i] = 1'b1;
              cnt_d[i]   = 8'd0;
            end else if (cnt_q[i] == LAST_CNT) begin
              miss_p0[i] = 1'b1;
              state_d[i] = ST_IDLE;
              cnt_d[i]   = 8'd0;
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = 8'd0;
          end
        endcase
      end
    end
  end

  // Score/combo use the pre-update combo to pick the multiplier.
  always_comb begin
    nh      = count_hits(hit_p0);
    score_d = sat_score(score_p1, nh, combo_p1 >= BONUS_AT);
    combo_d = sat_combo(combo_p1, nh, |miss_p0);
  end

  // Stage p1: registered grades, lane state and totals.
  always_ff @(posedge clk) begin
    if (rst || game_start) begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= 8'd0;
      end
      hit_p1   <= '0;
      miss_p1  <= '0;
      score_p1 <= '0;
      combo_p1 <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      hit_p1   <= hit_p0;
      miss_p1  <= miss_p0;
      score_p1 <= score_d;
      combo_p1 <= combo_d;
    end
  end

  assign hit   = hit_p1;
  assign miss  = miss_p1;
  assign score = score_p1;
  assign combo = combo_p1;

endmodule

// File: tb/tb_note_judge.sv
// Directed bench for note_judge: a default instance plus a SCORE_W=4 instance sharing stimulus.
module tb_note_judge;
  logic        clk = 1'b0;
  logic        rst;
  logic        game_start;
  logic [2:0]  mode;
  logic [3:0]  press;
  logic [3:0]  note_arrive;
  logic [3:0]  hit, miss, hit_s, miss_s;
  logic [15:0] score;
  logic [3:0]  score_s;
  logic [7:0]  combo, combo_s;
  int vec  = 0;
  int errs = 0;
  logic [3:0] miss_acc;

  always #5 clk = ~clk;

  note_judge dut (
    .clk(clk), .rst(rst), .mode(mode), .game_start(game_start), .press(press),
    .note_arrive(note_arrive), .hit(hit), .miss(miss), .score(score), .combo(combo)
  );

  note_judge #(.SCORE_W(4)) dut_s (
    .clk(clk), .rst(rst), .mode(mode), .game_start(game_start), .press(press),
    .note_arrive(note_arrive), .hit(hit_s), .miss(miss_s), .score(score_s), .combo(combo_s)
  );

  task automatic cyc(input logic [3:0] a, input logic [3:0] p);
    note_arrive = a;
    press       = p;
    @(posedge clk);
    #1;
    note_arrive = '0;
    press       = '0;
  endtask

  task automatic new_game();
    game_start = 1'b1;
    @(posedge clk);
    #1;
    game_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000);
    rst = 1'b0;
    if (hit !== 4'd0) begin errs++; $display("FAIL reset_hit got %b want 0000", hit); end
    vec++;
    if (miss !== 4'd0) begin errs++; $display("FAIL reset_miss got %b want 0000", miss); end
    vec++;
    if (score !== 16'd0 || combo !== 8'd0) begin
      errs++; $display("FAIL reset_totals got %0d/%0d want 0/0", score, combo);
    end
    vec++;
  endtask

  task automatic test_rst_mid_window();
    cyc(4'b0010, 4'b0010);
    if (hit !== 4'b0010 || score !== 16'd1 || combo !== 8'd1) begin
      errs++; $display("FAIL pre_rst_hit got %b %0d %0d want 0010 1 1", hit, score, combo);
    end
    vec++;
    cyc(4'b0001, 4'b0000);
    for (int i = 0; i < 7; i++) cyc(4'b0000, 4'b0000);
    rst = 1'b1;
    cyc(4'b0000, 4'b0000);
    rst = 1'b0;
    if (hit !== 4'd0 || miss !== 4'd0) begin
      errs++; $display("FAIL rst_mid_grades got %b/%b want 0000/0000", hit, miss);
    end
    vec++;
    if (score !== 16'd0 || combo !== 8'd0) begin
      errs++; $display("FAIL rst_mid_totals got %0d/%0d want 0/0", score, combo);
    end
    vec++;
    cyc(4'b0000, 4'b0001);
    if (miss !== 4'b0001 || hit !== 4'd0) begin
      errs++; $display("FAIL rst_stray got miss=%b hit=%b want 0001/0000", miss, hit);
    end
    vec++;
  endtask

  task automatic test_window();
    new_game();
    cyc(4'b0010, 4'b0000);
    miss_acc = '0;
    for (int i = 0; i < 13; i++) begin
      cyc(4'b0000, 4'b0000);
      miss_acc = miss_acc | miss;
    end
    if (miss_acc !== 4'd0) begin errs++; $display("FAIL window_early_miss got %b want 0000", miss_acc); end
    vec++;
    cyc(4'b0000, 4'b0010);
    if (hit !== 4'b0010 || miss !== 4'd0) begin
      errs++; $display("FAIL window_last_hit got hit=%b miss=%b want 0010/0000", hit, miss);
    end
    vec++;
    if (score !== 16'd1 || combo !== 8'd1) begin
      errs++; $display("FAIL window_last_totals got %0d/%0d want 1/1", score, combo);
    end
    vec++;
    new_game();
    cyc(4'b0010, 4'b0000);
    for (int i = 0; i < 13; i++) cyc(4'b0000, 4'b0000);
    if (miss !== 4'd0) begin errs++; $display("FAIL window_n13 got %b want 0000", miss); end
    vec++;
    cyc(4'b0000, 4'b0000);
    if (miss !== 4'b0010) begin errs++; $display("FAIL window_expiry got %b want 0010", miss); end
    vec++;
    cyc(4'b0000, 4'b0010);
    if (miss !== 4'b0010 || hit !== 4'd0) begin
      errs++; $display("FAIL window_late_stray got miss=%b hit=%b want 0010/0000", miss, hit);
    end
    vec++;
    if (score !== 16'd0 || combo !== 8'd0) begin
      errs++; $display("FAIL window_late_totals got %0d/%0d want 0/0", score, combo);
    end
    vec++;
  endtask

  task automatic test_combo_bonus();
    new_game();
    cyc(4'b1111, 4'b1111);
    cyc(4'b1111, 4'b1111);
    cyc(4'b0111, 4'b1111);
    if (score !== 16'd11 || combo !== 8'd0) begin
      errs++; $display("FAIL mixed_setup got %0d/%0d want 11/0", score, combo);
    end
    vec++;
    cyc(4'b1111, 4'b1111);
    cyc(4'b1111, 4'b1111);
    cyc(4'b0001, 4'b0001);
    if (score !== 16'd20 || combo !== 8'd9) begin
      errs++; $display("FAIL bonus_setup got %0d/%0d want 20/9", score, combo);
    end
    vec++;
    cyc(4'b0101, 4'b0101);
    if (score !== 16'd22 || combo !== 8'd11) begin
      errs++; $display("FAIL bonus_edge got %0d/%0d want 22/11", score, combo);
    end
    vec++;
    cyc(4'b0100, 4'b0100);
    if (score !== 16'd24 || combo !== 8'd12) begin
      errs++; $display("FAIL bonus_double got %0d/%0d want 24/12", score, combo);
    end
    vec++;
  endtask

  task automatic test_hit_miss_same();
    cyc(4'b0001, 4'b1001);
    if (hit !== 4'b0001 || miss !== 4'b1000) begin
      errs++; $display("FAIL same_grades got hit=%b miss=%b want 0001/1000", hit, miss);
    end
    vec++;
    if (score !== 16'd26 || combo !== 8'd0) begin
      errs++; $display("FAIL same_totals got %0d/%0d want 26/0", score, combo);
    end
    vec++;
  endtask

  task automatic test_game_start();
    new_game();
    if (score !== 16'd0 || combo !== 8'd0 || hit !== 4'd0 || miss !== 4'd0) begin
      errs++; $display("FAIL game_start got %0d/%0d %b/%b want 0/0 0000/0000", score, combo, hit, miss);
    end
    vec++;
  endtask

  task automatic test_saturation();
    new_game();
    for (int i = 0; i < 3; i++) cyc(4'b1111, 4'b1111);
    cyc(4'b0001, 4'b0001);
    if (score_s !== 4'd14 || combo_s !== 8'd13) begin
      errs++; $display("FAIL sat_setup got %0d/%0d want 14/13", score_s, combo_s);
    end
    vec++;
    cyc(4'b0001, 4'b0001);
    if (score_s !== 4'd15) begin errs++; $display("FAIL score_sat got %0d want 15", score_s); end
    vec++;
    for (int i = 0; i < 62; i++) cyc(4'b1111, 4'b1111);
    if (combo !== 8'd255 || score_s !== 4'd15) begin
      errs++; $display("FAIL combo_sat got %0d/%0d want 255/15", combo, score_s);
    end
    vec++;
    cyc(4'b0010, 4'b0010);
    if (combo !== 8'd255 || combo_s !== 8'd255) begin
      errs++; $display("FAIL combo_hold got %0d/%0d want 255/255", combo, combo_s);
    end
    vec++;
    if (score !== 16'd514) begin errs++; $display("FAIL wide_score got %0d want 514", score); end
    vec++;
  endtask

  task automatic test_mode();
    new_game();
    cyc(4'b0001, 4'b0001);
    cyc(4'b0100, 4'b0000);
    mode = 3'd3;
    miss_acc = '0;
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0000, 4'b0000);
      miss_acc = miss_acc | miss | hit;
    end
    if (miss_acc !== 4'd0) begin errs++; $display("FAIL mode_off_pulses got %b want 0000", miss_acc); end
    vec++;
    cyc(4'b1111, 4'b1111);
    if (hit !== 4'd0 || miss !== 4'd0) begin
      errs++; $display("FAIL mode_off_grades got hit=%b miss=%b want 0000/0000", hit, miss);
    end
    vec++;
    if (score !== 16'd1 || combo !== 8'd1) begin
      errs++; $display("FAIL mode_off_hold got %0d/%0d want 1/1", score, combo);
    end
    vec++;
    mode = 3'd4;
    cyc(4'b0000, 4'b0100);
    if (miss !== 4'b0100 || hit !== 4'd0 || combo !== 8'd0 || score !== 16'd1) begin
      errs++; $display("FAIL mode_back got miss=%b hit=%b %0d/%0d want 0100/0000 1/0", miss, hit, score, combo);
    end
    vec++;
  endtask

  initial begin
    rst = 1'b1; game_start = 1'b0; mode = 3'd4; press = '0; note_arrive = '0;
    test_reset();
    test_rst_mid_window();
    test_window();
    test_combo_bonus();
    test_hit_miss_same();
    test_game_start();
    test_saturation();
    test_mode();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
